// File: rtl/ecall_halt_unit.sv
// ecall_halt_unit: decides whether an ECALL in decode is a halt request.
// x17 is resolved through the ID/EX, EX/MEM and MEM/WB stages. Decode is
// stalled while x17 is still in flight. Once a halt is accepted, fetch is
// frozen so the older instructions can drain. A sticky is_halted flag is
// then raised, and the cycle counter stops.
module ecall_halt_unit #(
  parameter logic [31:0] HALT_CODE    = 32'd10,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_is_ecall,
  input  logic [31:0]      rf_x17,
  input  logic             idex_reg_write,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_reg_write,
  input  logic             exmem_mem_read,
  input  logic [4:0]       exmem_rd,
  input  logic [31:0]      exmem_alu_out,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic [31:0]      memwb_wb_data,
  output logic             ecall_stall,
  output logic             halt_fetch,
  output logic             is_halted,
  output logic [CNT_W-1:0] cycle_count
);

  // Drain counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int              DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0]  DRAIN_INIT = DCW'(DRAIN_CYCLES - 1);
  localparam logic [DCW-1:0]  DRAIN_ONE  = DCW'(1);
  localparam logic [DCW-1:0]  DRAIN_ZERO = DCW'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [4:0]      X17_IDX    = 5'd17;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             state_r;
  logic [DCW-1:0]     drain_cnt_r;
  logic               is_halted_r;
  logic [CNT_W-1:0]   cycle_count_r;

  logic               x17_ready_s;
  logic [31:0]        x17_val_s;
  logic               halt_accept_s;

  // Resolve x17 for the ECALL in decode; the youngest producer wins.
  always_comb begin
    x17_ready_s = 1'b1;
    x17_val_s   = rf_x17;
    if (!id_is_ecall) begin
      x17_ready_s = 1'b1;
      x17_val_s   = rf_x17;
    end else if (idex_reg_write && (idex_rd == X17_IDX)) begin
      // Producer still in EX: its value does not exist yet.
      x17_ready_s = 1'b0;
    end else if (exmem_reg_write && (exmem_rd == X17_IDX)) begin
      if (exmem_mem_read) begin
        // Load data only becomes available in MEM/WB.
        x17_ready_s = 1'b0;
      end else begin
        x17_val_s = exmem_alu_out;
      end
    end else if (memwb_reg_write && (memwb_rd == X17_IDX)) begin
      x17_val_s = memwb_wb_data;
    end else begin
      x17_val_s = rf_x17;
    end
  end

  // Stall / freeze requests and halt acceptance; all are suppressed under reset.
  always_comb begin
    ecall_stall   = 1'b0;
    halt_fetch    = 1'b0;
    halt_accept_s = 1'b0;
    if (reset) begin
      ecall_stall   = 1'b0;
      halt_fetch    = 1'b0;
      halt_accept_s = 1'b0;
    end else begin
      ecall_stall   = id_is_ecall && !x17_ready_s && (state_r == ST_RUN);
      halt_fetch    = (state_r != ST_RUN);
      halt_accept_s = (state_r == ST_RUN) && id_is_ecall && x17_ready_s &&
                      (x17_val_s == HALT_CODE);
    end
  end

  // Halt sequencing: RUN -> DRAIN (older instructions retire) -> HALTED (sticky).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= DRAIN_ZERO;
      is_halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (halt_accept_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= DRAIN_INIT;
          end else begin
            state_r     <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == DRAIN_ZERO) begin
            state_r     <= ST_HALTED;
            is_halted_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
          end
        end
        ST_HALTED: begin
          state_r     <= ST_HALTED;
          is_halted_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_RUN;
          drain_cnt_r <= DRAIN_ZERO;
          is_halted_r <= 1'b0;
        end
      endcase
    end
  end

  // Count every cycle until halted, then hold the value; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_r <= CNT_ZERO;
    end else if (!is_halted_r) begin
      cycle_count_r <= cycle_count_r + CNT_ONE;
    end else begin
      cycle_count_r <= cycle_count_r;
    end
  end

  assign is_halted   = is_halted_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_ecall_halt_unit.sv
// Testbench for ecall_halt_unit: each task drives one scenario. It pushes the
// expected {ecall_stall, halt_fetch, is_halted, cycle_count} to a queue, then
// pops and compares on the falling edge.
module tb_ecall_halt_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_is_ecall;
  logic [31:0] rf_x17;
  logic        idex_reg_write;
  logic [4:0]  idex_rd;
  logic        exmem_reg_write;
  logic        exmem_mem_read;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu_out;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wb_data;
  logic        ecall_stall, halt_fetch, is_halted;
  logic [31:0] cycle_count;
  logic        stall4, hf4, halted4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  ecall_halt_unit dut (
    .clk(clk), .reset(reset), .id_is_ecall(id_is_ecall), .rf_x17(rf_x17),
    .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
    .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_wb_data(memwb_wb_data), .ecall_stall(ecall_stall),
    .halt_fetch(halt_fetch), .is_halted(is_halted), .cycle_count(cycle_count)
  );

  // Narrow-counter instance to observe wrap-around within a short run.
  ecall_halt_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_is_ecall(id_is_ecall), .rf_x17(rf_x17),
    .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
    .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_wb_data(memwb_wb_data), .ecall_stall(stall4),
    .halt_fetch(hf4), .is_halted(halted4), .cycle_count(cnt4)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned m_cnt = 0;
  bit          m_halted = 1'b0;
  logic [34:0] exp_q[$];
  logic [34:0] obs, ex;

  task automatic set_in(input logic ec, input logic [31:0] rf,
                        input logic iw, input logic [4:0] ir,
                        input logic ew, input logic em, input logic [4:0] er,
                        input logic [31:0] ea,
                        input logic mw, input logic [4:0] mr, input logic [31:0] md);
    id_is_ecall = ec;  rf_x17 = rf;
    idex_reg_write = iw;  idex_rd = ir;
    exmem_reg_write = ew; exmem_mem_read = em; exmem_rd = er; exmem_alu_out = ea;
    memwb_reg_write = mw; memwb_rd = mr; memwb_wb_data = md;
  endtask

  task automatic idle();
    set_in(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // One rising edge; the expected counter follows the cycle-count rules.
  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_cnt = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic expect_out(input logic s, input logic hf, input logic h);
    exp_q.push_back({s, hf, h, m_cnt[31:0]});
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); advance();
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL reset_clear: got %h want %h", obs, ex); end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    // Hazard plus halt code under reset: both outputs must stay low.
    set_in(1'b1, 32'd10, 1'b1, 5'd17, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    advance(); advance();
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL reset_state: got %h want %h", obs, ex); end
    idle(); reset = 1'b0;
  endtask

  task automatic test_basic_halt();
    do_reset();
    advance(); set_in(1'b1, 32'd10, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL basic_accept: got %h want %h", obs, ex); end
    // Accept edge; a hazarding ECALL during drain must be ignored.
    advance(); set_in(1'b1, 32'd10, 1'b1, 5'd17, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_out(1'b0, 1'b1, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL basic_drain1: got %h want %h", obs, ex); end
    advance();
    expect_out(1'b0, 1'b1, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL basic_drain2: got %h want %h", obs, ex); end
    advance(); idle();
    expect_out(1'b0, 1'b1, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL basic_drain3: got %h want %h", obs, ex); end
    advance(); m_halted = 1'b1;
    expect_out(1'b0, 1'b1, 1'b1); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL basic_halted: got %h want %h", obs, ex); end
    advance(); advance();
    expect_out(1'b0, 1'b1, 1'b1); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL basic_frozen: got %h want %h", obs, ex); end
  endtask

  task automatic test_no_halt_cases();
    do_reset();
    // EX/MEM forwards 5: not a halt.
    advance(); set_in(1'b1, 32'd10, 1'b0, 5'd0, 1'b1, 1'b0, 5'd17, 32'd5, 1'b0, 5'd0, 32'd0);
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL exmem_fwd_stall: got %h want %h", obs, ex); end
    advance(); idle();
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL exmem_fwd_nohalt: got %h want %h", obs, ex); end
    // EX/MEM (11) outranks MEM/WB (10).
    advance(); set_in(1'b1, 32'd10, 1'b0, 5'd0, 1'b1, 1'b0, 5'd17, 32'd11, 1'b1, 5'd17, 32'd10);
    advance(); idle();
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL exmem_priority: got %h want %h", obs, ex); end
    // Upper bits differ from the halt code: full-width compare rejects it.
    advance(); set_in(1'b1, 32'h0001_000A, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    advance(); idle();
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL full_width_cmp: got %h want %h", obs, ex); end
    // Non-matching producers (rd 16, write disabled, rd 0) leave the RF value of 10 in charge.
    advance(); set_in(1'b1, 32'd10, 1'b1, 5'd16, 1'b0, 1'b1, 5'd17, 32'd3, 1'b1, 5'd0, 32'd5);
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL nonmatch_nostall: got %h want %h", obs, ex); end
    advance(); idle();
    expect_out(1'b0, 1'b1, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL nonmatch_rf_halt: got %h want %h", obs, ex); end
  endtask

  task automatic test_stall_chain();
    do_reset();
    advance(); set_in(1'b1, 32'd0, 1'b1, 5'd17, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_out(1'b1, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL stall_idex: got %h want %h", obs, ex); end
    advance(); set_in(1'b1, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd17, 32'd99, 1'b0, 5'd0, 32'd0);
    expect_out(1'b1, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL stall_load: got %h want %h", obs, ex); end
    advance(); set_in(1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'd10);
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL stall_release: got %h want %h", obs, ex); end
    advance(); idle();
    expect_out(1'b0, 1'b1, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL stall_then_drain: got %h want %h", obs, ex); end
    advance(); advance(); advance(); m_halted = 1'b1;
    expect_out(1'b0, 1'b1, 1'b1); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL stall_halted: got %h want %h", obs, ex); end
  endtask

  task automatic test_memwb_forward();
    do_reset();
    advance(); set_in(1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'd10);
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL memwb_accept: got %h want %h", obs, ex); end
    advance(); idle();
    expect_out(1'b0, 1'b1, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL memwb_drain: got %h want %h", obs, ex); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    advance(); set_in(1'b1, 32'd10, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    advance(); idle();
    advance();
    reset = 1'b1;
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL drain_reset_comb: got %h want %h", obs, ex); end
    advance(); reset = 1'b0;
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL drain_reset_run: got %h want %h", obs, ex); end
    advance(); set_in(1'b1, 32'd10, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    advance(); idle();
    advance(); advance(); advance(); m_halted = 1'b1;
    expect_out(1'b0, 1'b1, 1'b1); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL drain_reset_rehalt: got %h want %h", obs, ex); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) advance();
    expect_out(1'b0, 1'b0, 1'b0); @(negedge clk);
    obs = {ecall_stall, halt_fetch, is_halted, cycle_count}; ex = exp_q.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL count_20: got %h want %h", obs, ex); end
    checks++;
    if (cnt4 !== 4'd4) begin errors++; $display("FAIL count_wrap4: got %0d want %0d", cnt4, 4); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_wrap();
    test_basic_halt();
    test_no_halt_cases();
    test_stall_chain();
    test_memwb_forward();
    test_reset_in_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
